// File: rtl/serail_uart.sv
// serail_uart: byte UART controller behind the CPU serial bus port.
//   clk, rst                 : bus clock, synchronous active-high reset
//   serail_ce_i/we_i/addr_i  : access request, write enable, register select
//                              (0 = DATA, 1 = STATUS)
//   serail_data_i/data_o     : write data ([7:0] used) / read data
//   serail_ready_o           : one-cycle access-complete pulse
//   uart_rxd / uart_txd      : serial line in (async) / out (idles high)
//   int_o                    : RX data pending
// Build option: define SERAIL_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO;
// otherwise the RX buffer is a single holding byte.
`timescale 1ns/1ps

module serail_uart #(
    parameter int unsigned CLK_DIV  = 434,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serail_ce_i,
    input  logic        serail_we_i,
    input  logic        serail_addr_i,
    input  logic [31:0] serail_data_i,
    output logic [31:0] serail_data_o,
    output logic        serail_ready_o,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        int_o
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int unsigned LVL_W = PTR_W + 1;
`ifdef SERAIL_RX_FIFO_EN
    localparam int unsigned RX_CAP = RX_DEPTH;
`else
    localparam int unsigned RX_CAP = 1;
`endif

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Upper write-data bits carry nothing for this block
    logic unused_data_c;
    assign unused_data_c = ^serail_data_i[31:8];

    // ---------------- bus decode ----------------
    logic             acc_c, rd_data_c, rd_status_c, wr_data_c;
    logic             tx_full, rx_overrun;
    logic [7:0]       tx_hold, rx_head_c;
    logic [LVL_W-1:0] rx_level;
    logic             rx_avail_c, pop_c;
    logic [31:0]      status_c;

    assign acc_c       = serail_ce_i && !serail_ready_o;
    assign rd_data_c   = acc_c && !serail_we_i && !serail_addr_i;
    assign rd_status_c = acc_c && !serail_we_i &&  serail_addr_i;
    assign wr_data_c   = acc_c &&  serail_we_i && !serail_addr_i;
    assign rx_avail_c  = (rx_level != '0);
    assign pop_c       = rd_data_c && rx_avail_c;
    assign status_c    = {29'b0, rx_overrun, rx_avail_c, !tx_full};

    // Read data is presented only during the ready pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            serail_ready_o <= 1'b0;
            serail_data_o  <= '0;
        end else begin
            serail_ready_o <= acc_c;
            if (acc_c && !serail_we_i)
                serail_data_o <= serail_addr_i ? status_c
                                               : {24'b0, pop_c ? rx_head_c : 8'h00};
            else
                serail_data_o <= '0;
        end
    end

    // ---------------- TX ----------------
    tx_state_t        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             txd_n, tx_load_c, tx_last_c;

    // Holding register: filled by the bus, emptied when the shifter loads
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_full <= 1'b0;
            tx_hold <= 8'h00;
        end else if (tx_load_c) begin
            tx_full <= 1'b0;
        end else if (wr_data_c && !tx_full) begin
            tx_full <= 1'b1;
            tx_hold <= serail_data_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            uart_txd <= txd_n;
        end
    end

    assign tx_last_c = (tx_cnt == CNT_W'(CLK_DIV - 1));

    // TX next state; line level derived from the next state so it is registered
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CNT_W'(1);
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_load_c  = 1'b0;
        txd_n      = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (tx_full) begin
                    tx_state_n = TX_START;
                    tx_load_c  = 1'b1;
                    tx_shift_n = tx_hold;
                end
            end
            TX_START: begin
                if (tx_last_c) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                end
            end
            TX_DATA: begin
                if (tx_last_c) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7)
                        tx_state_n = TX_STOP;
                    else
                        tx_bit_n = tx_bit + 3'd1;
                end
            end
            TX_STOP: begin
                if (tx_last_c) begin
                    tx_cnt_n = '0;
                    if (tx_full) begin
                        tx_state_n = TX_START;
                        tx_load_c  = 1'b1;
                        tx_shift_n = tx_hold;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        case (tx_state_n)
            TX_START: txd_n = 1'b0;
            TX_DATA:  txd_n = tx_shift_n[0];
            default:  txd_n = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             rx_s1, rx_s2, rx_prev;
    logic             rx_fall_c, rx_push_c, rx_full_c, rx_push_ok_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall_c = rx_prev && !rx_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // rx_cnt counts cycles since the synchronised falling edge (START) or
    // since the previous sample (DATA/STOP)
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CNT_W'(1);
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push_c  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = CNT_W'(2);
                if (rx_fall_c)
                    rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == CNT_W'(HALF)) begin
                    rx_cnt_n = CNT_W'(1);
                    if (rx_s2) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_bit_n   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == CNT_W'(CLK_DIV)) begin
                    rx_cnt_n   = CNT_W'(1);
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    if (rx_bit == 3'd7)
                        rx_state_n = RX_STOP;
                    else
                        rx_bit_n = rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == CNT_W'(CLK_DIV)) begin
                    rx_push_c  = rx_s2;
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- RX buffer ----------------
    assign rx_full_c    = (rx_level == LVL_W'(RX_CAP));
    assign rx_push_ok_c = rx_push_c && !rx_full_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_level   <= '0;
            rx_overrun <= 1'b0;
            int_o      <= 1'b0;
        end else begin
            if (rx_push_ok_c && !pop_c)
                rx_level <= rx_level + LVL_W'(1);
            else if (!rx_push_ok_c && pop_c)
                rx_level <= rx_level - LVL_W'(1);
            // A new overrun wins over a same-cycle STATUS clear
            if (rx_push_c && rx_full_c)
                rx_overrun <= 1'b1;
            else if (rd_status_c)
                rx_overrun <= 1'b0;
            int_o <= rx_avail_c;
        end
    end

`ifdef SERAIL_RX_FIFO_EN
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;

    always_ff @(posedge clk) begin
        if (rx_push_ok_c)
            rx_mem[rx_wr_ptr] <= rx_shift;
    end

    // Pointers wrap naturally since RX_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push_ok_c)
                rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
            if (pop_c)
                rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
        end
    end

    assign rx_head_c = rx_mem[rx_rd_ptr];
`else
    logic [7:0] rx_hold;

    always_ff @(posedge clk) begin
        if (rst)
            rx_hold <= 8'h00;
        else if (rx_push_ok_c)
            rx_hold <= rx_shift;
    end

    assign rx_head_c = rx_hold;
`endif

endmodule

// File: tb/tb_serail_uart.sv
// Self-checking bench for serail_uart (CLK_DIV = 8); RX buffer capacity
// follows the SERAIL_RX_FIFO_EN build option.
`timescale 1ns/1ps

module tb_serail_uart;

    localparam int unsigned DIV   = 8;
    localparam int unsigned DEPTH = 16;
`ifdef SERAIL_RX_FIFO_EN
    localparam int unsigned CAP = DEPTH;
`else
    localparam int unsigned CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0, we = 1'b0, addr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata_o;
    logic        ready;
    logic        rxd = 1'b1;
    logic        txd;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: RX contents as a queue, sticky overrun flag
    logic [7:0] m_q[$];
    bit         m_ovr = 1'b0;

    serail_uart #(.CLK_DIV(DIV), .RX_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .serail_ce_i    (ce),
        .serail_we_i    (we),
        .serail_addr_i  (addr),
        .serail_data_i  (wdata),
        .serail_data_o  (rdata_o),
        .serail_ready_o (ready),
        .uart_rxd       (rxd),
        .uart_txd       (txd),
        .int_o          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = {29'b0, m_ovr, (m_q.size() != 0), 1'b1};
        m_ovr = 1'b0;
        return s;
    endfunction

    function automatic logic [31:0] model_pop();
        if (m_q.size() == 0) return 32'h0;
        return {24'b0, m_q.pop_front()};
    endfunction

    // One bus access; ok = ready seen exactly one cycle after the request
    task automatic bus_access(input logic a_we, input logic a_addr,
                              input logic [31:0] a_wd,
                              output logic [31:0] a_rd, output bit ok);
        int n;
        ce = 1'b1; we = a_we; addr = a_addr; wdata = a_wd;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (ready !== 1'b1 && n < 4);
        ok   = (ready === 1'b1) && (n == 1);
        a_rd = rdata_o;
        ce = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    // Drive one frame on uart_rxd; the model follows the receive rules
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (DIV) @(posedge clk);
        #1;
        rxd = 1'b1;
        if (stop) begin
            if (m_q.size() < CAP) m_q.push_back(b);
            else m_ovr = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; bit ok;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", irq); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rdata_o); end
        rst = 1'b0;
        m_q.delete(); m_ovr = 1'b0;
        @(posedge clk); #1;
        bus_access(1'b0, 1'b1, 32'h0, rd, ok);
        n_checks++; if (!ok || rd !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h ok=%0d want 00000001", rd, ok); end
    endtask

    task automatic test_tx();
        logic [31:0] rd; bit ok;
        logic [7:0] b1, b2;
        bit exp[$];
        b1 = 8'hA5;
        b2 = 8'($urandom);
        for (int f = 0; f < 2; f++) begin
            logic [7:0] b;
            b = (f == 0) ? b1 : b2;
            repeat (DIV) exp.push_back(1'b0);
            for (int k = 0; k < 8; k++) repeat (DIV) exp.push_back(b[k]);
            repeat (DIV) exp.push_back(1'b1);
        end
        repeat (20) exp.push_back(1'b1);

        bus_access(1'b1, 1'b0, {24'h0, b1}, rd, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tx_write1: ready got %0d want 1", ok); end
        fork
            begin
                for (int i = 0; i < exp.size(); i++) begin
                    if (i > 0) begin @(posedge clk); #1; end
                    n_checks++;
                    if (txd !== exp[i]) begin
                        n_fail++;
                        $display("FAIL tx_line[%0d]: got %b want %b", i, txd, exp[i]);
                    end
                end
            end
            begin
                logic [31:0] r2; bit ok2;
                bus_access(1'b0, 1'b1, 32'h0, r2, ok2);
                n_checks++; if (!ok2 || r2 !== 32'h1) begin n_fail++; $display("FAIL tx_ready_after_start: got %h want 00000001", r2); end
                bus_access(1'b1, 1'b0, {24'h0, b2}, r2, ok2);
                n_checks++; if (!ok2) begin n_fail++; $display("FAIL tx_write2: ready got %0d want 1", ok2); end
                bus_access(1'b0, 1'b1, 32'h0, r2, ok2);
                n_checks++; if (!ok2 || r2 !== 32'h0) begin n_fail++; $display("FAIL tx_busy_status: got %h want 00000000", r2); end
                bus_access(1'b1, 1'b0, 32'h000000FF, r2, ok2);
                n_checks++; if (!ok2) begin n_fail++; $display("FAIL tx_write_dropped: ready got %0d want 1", ok2); end
            end
        join
        bus_access(1'b0, 1'b1, 32'h0, rd, ok);
        n_checks++; if (!ok || rd !== 32'h1) begin n_fail++; $display("FAIL tx_idle_status: got %h want 00000001", rd); end
    endtask

    task automatic test_rx();
        logic [31:0] rd, ex; bit ok;
        int lat;
        lat = 0;
        fork
            send_frame(8'h3C, 1'b1);
            begin
                do begin @(posedge clk); #1; lat++; end while (irq !== 1'b1 && lat < 200);
            end
        join
        n_checks++; if (lat != 2 + DIV/2 + 9*DIV + 1) begin n_fail++; $display("FAIL rx_latency: got %0d want %0d", lat, 2 + DIV/2 + 9*DIV + 1); end
        ex = model_status();
        bus_access(1'b0, 1'b1, 32'h0, rd, ok);
        n_checks++; if (!ok || rd !== ex) begin n_fail++; $display("FAIL rx_status: got %h want %h", rd, ex); end
        ex = model_pop();
        bus_access(1'b0, 1'b0, 32'h0, rd, ok);
        n_checks++; if (!ok || rd !== ex) begin n_fail++; $display("FAIL rx_data: got %h want %h", rd, ex); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_int_clear: got %b want 0", irq); end

        // Random bursts of back-to-back frames, then drain
        for (int r = 0; r < 5; r++) begin
            int nb, nr;
            nb = int'($urandom_range(1, 3));
            for (int j = 0; j < nb; j++) send_frame(8'($urandom), 1'b1);
            ex = model_status();
            bus_access(1'b0, 1'b1, 32'h0, rd, ok);
            n_checks++; if (!ok || rd !== ex) begin n_fail++; $display("FAIL rx_burst_status[%0d]: got %h want %h", r, rd, ex); end
            nr = m_q.size() + 1;
            for (int j = 0; j < nr; j++) begin
                ex = model_pop();
                bus_access(1'b0, 1'b0, 32'h0, rd, ok);
                n_checks++; if (!ok || rd !== ex) begin n_fail++; $display("FAIL rx_burst_data[%0d.%0d]: got %h want %h", r, j, rd, ex); end
            end
        end
    endtask

    task automatic test_glitch_framing();
        logic [31:0] rd, ex; bit ok;
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL glitch_int: got %b want 0", irq); end
        ex = model_status();
        bus_access(1'b0, 1'b1, 32'h0, rd, ok);
        n_checks++; if (!ok || rd !== ex) begin n_fail++; $display("FAIL glitch_status: got %h want %h", rd, ex); end
        send_frame(8'h55, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL framing_int: got %b want 0", irq); end
        ex = model_pop();
        bus_access(1'b0, 1'b0, 32'h0, rd, ok);
        n_checks++; if (!ok || rd !== ex) begin n_fail++; $display("FAIL framing_data: got %h want %h", rd, ex); end
    endtask

    task automatic test_overrun();
        logic [31:0] rd, ex; bit ok;
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        ex = model_status();
        bus_access(1'b0, 1'b1, 32'h0, rd, ok);
        n_checks++; if (!ok || rd !== ex) begin n_fail++; $display("FAIL ovr_status: got %h want %h", rd, ex); end
        for (int j = 0; j <= CAP; j++) begin
            ex = model_pop();
            bus_access(1'b0, 1'b0, 32'h0, rd, ok);
            n_checks++; if (!ok || rd !== ex) begin n_fail++; $display("FAIL ovr_data[%0d]: got %h want %h", j, rd, ex); end
        end
        ex = model_status();
        bus_access(1'b0, 1'b1, 32'h0, rd, ok);
        n_checks++; if (!ok || rd !== ex) begin n_fail++; $display("FAIL ovr_cleared: got %h want %h", rd, ex); end
    endtask

    task automatic test_handshake();
        logic [31:0] rd, ex; bit ok;
        send_frame(8'($urandom), 1'b1);
        send_frame(8'($urandom), 1'b1);
        ce = 1'b1; we = 1'b0; addr = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            logic er;
            @(posedge clk); #1;
            er = (c % 2 == 1);
            n_checks++; if (ready !== er) begin n_fail++; $display("FAIL hs_ready[%0d]: got %b want %b", c, ready, er); end
            if (er) begin
                ex = model_pop();
                n_checks++; if (rdata_o !== ex) begin n_fail++; $display("FAIL hs_data[%0d]: got %h want %h", c, rdata_o, ex); end
            end
        end
        ce = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL hs_idle: got %b want 0", ready); end
        ex = model_pop();
        bus_access(1'b0, 1'b0, 32'h0, rd, ok);
        n_checks++; if (!ok || rd !== ex) begin n_fail++; $display("FAIL hs_empty_read: got %h want %h", rd, ex); end
        ex = model_status();
        bus_access(1'b0, 1'b1, 32'h0, rd, ok);
        n_checks++; if (!ok || rd !== ex) begin n_fail++; $display("FAIL hs_status: got %h want %h", rd, ex); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd; bit ok, low_seen;
        send_frame(8'($urandom), 1'b1);
        bus_access(1'b1, 1'b0, 32'h0000005A, rd, ok);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL midrst_txd: got %b want 1", txd); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_int: got %b want 0", irq); end
        rst = 1'b0;
        m_q.delete(); m_ovr = 1'b0;
        low_seen = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) low_seen = 1'b1;
        end
        n_checks++; if (low_seen) begin n_fail++; $display("FAIL midrst_line_idle: got low want high"); end
        bus_access(1'b0, 1'b1, 32'h0, rd, ok);
        n_checks++; if (!ok || rd !== 32'h1) begin n_fail++; $display("FAIL midrst_status: got %h want 00000001", rd); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_glitch_framing();
        test_overrun();
        test_handshake();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serail_uart.md
# serail_uart

Byte-oriented UART controller that sits directly behind the CPU's serial bus port (`serail_*` signals) and drives the external COM line. It accepts register reads/writes from the CPU bus master with a one-cycle ready handshake, serialises transmit bytes onto `uart_txd`, and deserialises `uart_rxd` into a receive buffer. It raises a level interrupt for the `int_i[4]` (COM1) line whenever received data is pending.

## Interface
Parameters:
- `CLK_DIV`, 434: `clk` cycles per bit (50 MHz / 115200); legal range 4..65535.
- `RX_DEPTH`, 16: RX FIFO entries, power of two; used only when `SERAIL_RX_FIFO_EN` is defined.

Ports:
- `clk`  in  1  bus clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `serail_ce_i`  in  1  access request.
- `serail_we_i`  in  1  1 = write, 0 = read.
- `serail_addr_i`  in  1  0 = DATA register, 1 = STATUS register.
- `serail_data_i`  in  32  write data; only [7:0] used.
- `serail_data_o`  out  32  read data, valid while `serail_ready_o` = 1.
- `serail_ready_o`  out  1  one-cycle access-complete pulse.
- `uart_rxd`  in  1  asynchronous serial input.
- `uart_txd`  out  1  serial output; idles high.
- `int_o`  out  1  RX-data-pending interrupt.

## Operation
- Reset values: `serail_data_o` = 0, `serail_ready_o` = 0, `uart_txd` = 1, `int_o` = 0. All FIFOs empty, all flags clear, both FSMs idle.
- Bus access: a request is accepted on any cycle with `serail_ce_i` = 1 and `serail_ready_o` = 0. Side effects occur on acceptance.
- Read DATA: pops one RX byte and returns {24'b0, byte}. If RX is empty, returns 0 and nothing pops.
- Read STATUS: returns {29'b0, overrun, rx_avail, tx_ready}, then clears `overrun`.
- Write DATA: loads `serail_data_i[7:0]` into the TX holding register if `tx_ready` = 1. If `tx_ready` = 0, the byte is dropped and the access still completes.
- Write STATUS: ignored; the access still completes.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each state lasts `CLK_DIV` cycles. START drives 0, DATA sends 8 bits LSB first, STOP drives 1.
  - The holding register moves into the shifter when leaving IDLE. `tx_ready` returns to 1 at that moment, so a second byte can be queued during transmission.
  - From STOP, the FSM goes straight to START if the holding register is full (back-to-back frames, no idle gap).
- RX path: `uart_rxd` passes through a 2-flop synchroniser. RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE -> START on a synchronised falling edge.
  - At `CLK_DIV/2` (integer division), the start bit is re-sampled. If it reads 1, the FSM returns to IDLE (glitch rejection).
  - Data bits are sampled every `CLK_DIV` cycles after the start-bit sample, LSB first.
  - Stop sample = 1: the byte is pushed. Stop sample = 0: framing error, byte discarded, no flag.
  - The FSM returns to IDLE immediately after the stop sample.
- Overrun: a push while RX is full drops the new byte and sets sticky `overrun`. Stored data is kept.
- Simultaneous push and pop in the same cycle: both occur and the count is unchanged. If RX was empty, the pop returns 0 and the pushed byte stays.
- `int_o` = `rx_avail` = RX non-empty, driven from a register.

## Timing
- Access latency is 1 cycle: accepted at edge N, `serail_ready_o` = 1 and data valid during cycle N+1, for exactly one cycle.
- If `serail_ce_i` is still 1 in the cycle after the ready pulse, a new access is accepted. The master must deassert `serail_ce_i` to avoid a repeated pop.
- STATUS reflects state before the access's side effects. An RX push is visible to STATUS/`int_o` one cycle after the stop sample.
- After a write to an idle TX, `uart_txd` falls 1 cycle after the write is accepted. A frame lasts 10·`CLK_DIV` cycles.
- RX latency: from the falling edge on the pin to `int_o` = 1 is 2 (synchroniser) + `CLK_DIV/2` + 9·`CLK_DIV` + 1 cycles.
- `rst` asserted mid-frame: `uart_txd` = 1 on the next cycle, the partial byte is lost, and FIFO contents are discarded.

## Configuration
- `SERAIL_RX_FIFO_EN` defined: the RX buffer is a `RX_DEPTH`-entry circular FIFO. Pointers wrap modulo `RX_DEPTH`; full = count == `RX_DEPTH`.
- Not defined: the RX buffer is a single holding byte (depth 1). A second byte arriving before the read sets `overrun` and is dropped. `RX_DEPTH` is ignored.

## Test plan
All cases use `CLK_DIV` = 8.
- Reset: hold `rst` 3 cycles -> `uart_txd` = 1, `int_o` = 0, and a STATUS read returns 0x00000001.
- TX: write DATA 0x000000A5 -> `uart_txd` carries 0,1,0,1,0,0,1,0,1,1, each level lasting 8 cycles. `tx_ready` = 1 from one cycle after the frame starts. A second write queued during the frame follows back-to-back.
- RX: drive frame 0x3C on `uart_rxd` -> `int_o` rises, STATUS = 0x00000003, DATA read returns 0x0000003C, and `int_o` falls.
- Glitch/framing: a 3-cycle low pulse produces no byte. Frame 0x55 with stop bit = 0 is discarded and `int_o` stays 0.
- Overrun: with FIFO enabled, receive 17 bytes 0x00..0x10 without reading -> STATUS = 0x00000007. Reads return 0x00..0x0F, then 0. A second STATUS read shows overrun cleared.
- Handshake: hold `serail_ce_i` high for 4 cycles on DATA read -> `serail_ready_o` pulses on cycles 2 and 4 and two bytes pop. A read on empty RX returns 0x00000000.
